// File: rtl/regfile_writeback_if.sv
// Bundle of the producer channels, register-file write port and bypass queries
// for regfile_writeback; the design connects through the slave modport.
interface regfile_writeback_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;

  logic              wb_hold;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_wd;

  logic [ADDR_W-1:0] q1_rs;
  logic [ADDR_W-1:0] q2_rs;
  logic              q1_hit;
  logic              q2_hit;
  logic [DATA_W-1:0] q1_data;
  logic [DATA_W-1:0] q2_data;

  modport master (
    output alu_valid, alu_rd, alu_data, input alu_ready,
    output ld_valid, ld_rd, ld_data, input ld_ready,
    output wb_hold, input wb_we, wb_rd, wb_wd,
    output q1_rs, q2_rs, input q1_hit, q2_hit, q1_data, q2_data
  );

  modport slave (
    input alu_valid, alu_rd, alu_data, output alu_ready,
    input ld_valid, ld_rd, ld_data, output ld_ready,
    input wb_hold, output wb_we, wb_rd, wb_wd,
    input q1_rs, q2_rs, output q1_hit, q2_hit, q1_data, q2_data
  );
endinterface

// File: rtl/regfile_writeback.sv
// Write-side front end of the integer register file: round-robin ALU/load arbitration,
// in-order FIFO drained onto the single write port, youngest-wins bypass (WB_BYPASS_EN).
module regfile_writeback #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  regfile_writeback_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} src_e;

  src_e              prio_q, prio_d;
  logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
  logic [ADDR_W-1:0] fifo_rd_d   [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wb_we_q, wb_we_d;
  logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_wd_q, wb_wd_d;

  logic              alu_fire, ld_fire, push, pop;
  logic [ADDR_W-1:0] enq_rd;
  logic [DATA_W-1:0] enq_data;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign bus.alu_ready = !full && (!bus.ld_valid  || prio_q == SRC_ALU);
  assign bus.ld_ready  = !full && (!bus.alu_valid || prio_q == SRC_LD);

  assign bus.wb_we = wb_we_q;
  assign bus.wb_rd = wb_rd_q;
  assign bus.wb_wd = wb_wd_q;

  // At most one channel can fire; rd==0 completes the handshake but is never stored.
  always_comb begin
    alu_fire    = bus.alu_valid && bus.alu_ready;
    ld_fire     = bus.ld_valid  && bus.ld_ready;
    enq_rd      = alu_fire ? bus.alu_rd   : bus.ld_rd;
    enq_data    = alu_fire ? bus.alu_data : bus.ld_data;
    push        = (alu_fire || ld_fire) && (enq_rd != '0);
    pop         = !empty && !bus.wb_hold;

    prio_d      = prio_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wb_we_d     = pop;
    wb_rd_d     = wb_rd_q;
    wb_wd_d     = wb_wd_q;

    if (bus.alu_valid && bus.ld_valid && (alu_fire || ld_fire)) begin
      prio_d = (prio_q == SRC_ALU) ? SRC_LD : SRC_ALU;
    end

    if (push) begin
      fifo_rd_d[wr_ptr_q]   = enq_rd;
      fifo_data_d[wr_ptr_q] = enq_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      wb_rd_d  = fifo_rd_q[rd_ptr_q];
      wb_wd_d  = fifo_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= SRC_ALU;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wb_we_q  <= 1'b0;
      wb_rd_q  <= '0;
      wb_wd_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      prio_q      <= prio_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_wd_q     <= wb_wd_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
    end
  end

`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] q_rs   [2];
  logic              q_hit  [2];
  logic [DATA_W-1:0] q_data [2];
  logic [PTR_W-1:0]  idx;

  assign q_rs[0]     = bus.q1_rs;
  assign q_rs[1]     = bus.q2_rs;
  assign bus.q1_hit  = q_hit[0];
  assign bus.q2_hit  = q_hit[1];
  assign bus.q1_data = q_data[0];
  assign bus.q2_data = q_data[1];

  // Scan oldest to youngest (output register first) so later matches overwrite earlier ones.
  always_comb begin
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      q_hit[p]  = 1'b0;
      q_data[p] = '0;
      if (wb_we_q && wb_rd_q == q_rs[p]) begin
        q_hit[p]  = 1'b1;
        q_data[p] = wb_wd_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PTR_W'(i);
        if (CNT_W'(i) < count_q && fifo_rd_q[idx] == q_rs[p]) begin
          q_hit[p]  = 1'b1;
          q_data[p] = fifo_data_q[idx];
        end
      end
      if (q_rs[p] == '0) begin
        q_hit[p]  = 1'b0;
        q_data[p] = '0;
      end
    end
  end
`else
  logic unused_query;

  assign unused_query = ^{bus.q1_rs, bus.q2_rs};
  assign bus.q1_hit   = 1'b0;
  assign bus.q2_hit   = 1'b0;
  assign bus.q1_data  = '0;
  assign bus.q2_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus a randomized run
// compared against a queue-based reference model of the write-back front end.
module tb_regfile_writeback;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int n_vec;
  int n_bad;

  // Reference model: pending results in arrival order, plus the write-port registers.
  ent_t              m_q[$];
  bit                m_we;
  logic [ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0] m_wd;
  bit                m_prio_ld;
  bit                m_alu_acc;
  bit                m_ld_acc;

  regfile_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DATA_W:0] model_query(input logic [ADDR_W-1:0] rs);
    if (!BYP || rs == '0) return '0;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].rd == rs) return {1'b1, m_q[i].data};
    end
    if (m_we && m_rd == rs) return {1'b1, m_wd};
    return '0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_we      = 1'b0;
    m_rd      = '0;
    m_wd      = '0;
    m_prio_ld = 1'b0;
    m_alu_acc = 1'b0;
    m_ld_acc  = 1'b0;
  endtask

  // One clock edge of the reference: grant one source, drain the oldest, then append.
  task automatic model_edge();
    bit   av, lv, room, take_alu, take_ld;
    ent_t e;
    av       = bus.alu_valid;
    lv       = bus.ld_valid;
    room     = (m_q.size() < DEPTH);
    take_alu = 1'b0;
    take_ld  = 1'b0;
    if (room) begin
      if (av && lv) begin
        if (m_prio_ld) take_ld = 1'b1;
        else           take_alu = 1'b1;
      end else begin
        take_alu = av;
        take_ld  = lv;
      end
    end
    if (m_q.size() > 0 && !bus.wb_hold) begin
      e    = m_q.pop_front();
      m_we = 1'b1;
      m_rd = e.rd;
      m_wd = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (take_alu && bus.alu_rd != '0) begin
      e.rd = bus.alu_rd; e.data = bus.alu_data; m_q.push_back(e);
    end
    if (take_ld && bus.ld_rd != '0) begin
      e.rd = bus.ld_rd; e.data = bus.ld_data; m_q.push_back(e);
    end
    if (av && lv && (take_alu || take_ld)) m_prio_ld = !m_prio_ld;
    m_alu_acc = take_alu;
    m_ld_acc  = take_ld;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    bus.wb_hold   = 1'b0;
    bus.q1_rs     = '0;   bus.q2_rs  = '0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    bus.alu_valid = 1'b1;
    bus.ld_valid  = 1'b1;
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({bus.wb_we, bus.wb_rd, bus.wb_wd} !== '0) begin
      n_bad++; $display("[TB] FAIL reset_wb: got %0h expected 0", {bus.wb_we, bus.wb_rd, bus.wb_wd});
    end
    n_vec++;
    if ({count, empty, full} !== {3'd0, 1'b1, 1'b0}) begin
      n_bad++; $display("[TB] FAIL reset_count_flags: got %b expected 00010", {count, empty, full});
    end
    n_vec++;
    if ({bus.alu_ready, bus.ld_ready} !== 2'b10) begin
      n_bad++; $display("[TB] FAIL reset_ready: got %b expected 10", {bus.alu_ready, bus.ld_ready});
    end
    apply_reset();
  endtask

  task automatic test_latency();
    apply_reset();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'hAA;
    tick();
    bus.alu_valid = 1'b0;
    n_vec++;
    if ({bus.wb_we, count} !== {1'b0, 3'd1}) begin
      n_bad++; $display("[TB] FAIL latency_edge1: got we/count %b expected 0001", {bus.wb_we, count});
    end
    tick();
    n_vec++;
    if ({bus.wb_we, bus.wb_rd, bus.wb_wd} !== {1'b1, 5'd3, 64'hAA}) begin
      n_bad++; $display("[TB] FAIL latency_write: got we=%b rd=%0d wd=%0h expected 1/3/aa",
                        bus.wb_we, bus.wb_rd, bus.wb_wd);
    end
    tick();
    n_vec++;
    if (bus.wb_we !== 1'b0) begin
      n_bad++; $display("[TB] FAIL latency_done: got we=%b expected 0", bus.wb_we);
    end
  endtask

  task automatic test_arbitration();
    int                exp_rd[4];
    logic [ADDR_W-1:0] seen_rd[$];
    logic [DATA_W-1:0] seen_wd[$];
    int                a_rd, l_rd;
    bit                ar, lr;
    exp_rd = '{1, 11, 2, 12};
    apply_reset();
    a_rd = 1; l_rd = 11;
    for (int c = 0; c < 7; c++) begin
      bus.alu_valid = (c < 4); bus.alu_rd = ADDR_W'(a_rd); bus.alu_data = 64'(a_rd) << 8;
      bus.ld_valid  = (c < 4); bus.ld_rd  = ADDR_W'(l_rd); bus.ld_data  = 64'(l_rd) << 8;
      #1;
      ar = bus.alu_ready; lr = bus.ld_ready;
      if (c < 4) begin
        n_vec++;
        if ({ar, lr} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_bad++; $display("[TB] FAIL arb_ready_c%0d: got %b expected %b", c, {ar, lr},
                            (c % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      tick();
      if (c < 4 && ar) a_rd++;
      if (c < 4 && lr) l_rd++;
      if (bus.wb_we) begin
        seen_rd.push_back(bus.wb_rd);
        seen_wd.push_back(bus.wb_wd);
      end
    end
    n_vec++;
    if (seen_rd.size() != 4) begin
      n_bad++; $display("[TB] FAIL arb_write_count: got %0d expected 4", seen_rd.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if ({seen_rd[i], seen_wd[i]} !== {ADDR_W'(exp_rd[i]), 64'(exp_rd[i]) << 8}) begin
          n_bad++; $display("[TB] FAIL arb_order_%0d: got rd=%0d wd=%0h expected rd=%0d",
                            i, seen_rd[i], seen_wd[i], exp_rd[i]);
        end
      end
    end
  endtask

  task automatic test_full_hold();
    int acc;
    int a_rd;
    bit ar;
    apply_reset();
    bus.wb_hold = 1'b1;
    acc = 0; a_rd = 1;
    for (int c = 0; c < 5; c++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = ADDR_W'(a_rd); bus.alu_data = 64'(a_rd) << 8;
      #1;
      ar = bus.alu_ready;
      tick();
      if (ar) begin acc++; a_rd++; end
    end
    #1;
    n_vec++;
    if (acc != 4) begin
      n_bad++; $display("[TB] FAIL full_accepted: got %0d expected 4", acc);
    end
    n_vec++;
    if ({full, bus.alu_ready, count} !== {1'b1, 1'b0, 3'd4}) begin
      n_bad++; $display("[TB] FAIL full_flags: got full/rdy/count %b expected 10100",
                        {full, bus.alu_ready, count});
    end
    bus.alu_valid = 1'b0;
    bus.wb_hold   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if ({bus.wb_we, bus.wb_rd} !== {1'b1, ADDR_W'(k + 1)}) begin
        n_bad++; $display("[TB] FAIL drain_%0d: got we=%b rd=%0d expected we=1 rd=%0d",
                          k, bus.wb_we, bus.wb_rd, k + 1);
      end
    end
    n_vec++;
    if (empty !== 1'b1) begin
      n_bad++; $display("[TB] FAIL drain_empty: got %b expected 1", empty);
    end
    tick();
    n_vec++;
    if (bus.wb_we !== 1'b0) begin
      n_bad++; $display("[TB] FAIL drain_idle: got we=%b expected 0", bus.wb_we);
    end
  endtask

  task automatic test_bypass();
    logic [DATA_W:0] exp_hit;
    exp_hit = BYP ? {1'b1, 64'h20} : '0;
    apply_reset();
    bus.wb_hold   = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 64'h10;
    tick();
    bus.alu_data = 64'h20;
    tick();
    bus.alu_valid = 1'b0;
    bus.q1_rs = 5'd7; bus.q2_rs = 5'd5;
    #1;
    n_vec++;
    if ({bus.q1_hit, bus.q1_data} !== exp_hit) begin
      n_bad++; $display("[TB] FAIL bypass_fifo: got hit=%b data=%0h expected %0h",
                        bus.q1_hit, bus.q1_data, exp_hit);
    end
    n_vec++;
    if ({bus.q2_hit, bus.q2_data} !== '0) begin
      n_bad++; $display("[TB] FAIL bypass_miss: got hit=%b data=%0h expected 0", bus.q2_hit, bus.q2_data);
    end
    bus.wb_hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if ({bus.q1_hit, bus.q1_data} !== ((k < 2) ? exp_hit : '0)) begin
        n_bad++; $display("[TB] FAIL bypass_drain_%0d: got hit=%b data=%0h expected %0h", k,
                          bus.q1_hit, bus.q1_data, (k < 2) ? exp_hit : '0);
      end
    end
  endtask

  task automatic test_rd_zero();
    apply_reset();
    bus.alu_valid = 1'b1; bus.alu_rd = '0; bus.alu_data = 64'hFF;
    bus.q1_rs = '0;
    #1;
    n_vec++;
    if (bus.alu_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL rd0_ready: got %b expected 1", bus.alu_ready);
    end
    tick();
    bus.alu_valid = 1'b0;
    n_vec++;
    if ({count, bus.q1_hit} !== 4'b0000) begin
      n_bad++; $display("[TB] FAIL rd0_dropped: got count=%0d hit=%b expected 0/0", count, bus.q1_hit);
    end
    tick();
    n_vec++;
    if (bus.wb_we !== 1'b0) begin
      n_bad++; $display("[TB] FAIL rd0_nowrite: got we=%b expected 0", bus.wb_we);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.wb_hold = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = ADDR_W'(k); bus.alu_data = 64'(k);
      tick();
    end
    bus.alu_valid = 1'b0;
    bus.wb_hold   = 1'b0;
    tick();
    n_vec++;
    if ({bus.wb_we, count} !== {1'b1, 3'd2}) begin
      n_bad++; $display("[TB] FAIL midrst_before: got we/count %b expected 1010", {bus.wb_we, count});
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({bus.wb_we, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
      n_bad++; $display("[TB] FAIL midrst_now: got we/count/empty %b expected 00001",
                        {bus.wb_we, count, empty});
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if ({bus.wb_we, count} !== 4'b0000) begin
        n_bad++; $display("[TB] FAIL midrst_after_%0d: got we/count %b expected 0000", k, {bus.wb_we, count});
      end
    end
  endtask

  task automatic test_random();
    bit exp_ar, exp_lr;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (!bus.alu_valid || m_alu_acc) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd    = ADDR_W'($urandom_range(0, 7));
        bus.alu_data  = {$urandom, $urandom};
      end
      if (!bus.ld_valid || m_ld_acc) begin
        bus.ld_valid = 1'($urandom_range(0, 1));
        bus.ld_rd    = ADDR_W'($urandom_range(0, 7));
        bus.ld_data  = {$urandom, $urandom};
      end
      bus.wb_hold = ($urandom_range(0, 99) < ((c < 300) ? 25 : 60));
      bus.q1_rs   = ADDR_W'($urandom_range(0, 7));
      bus.q2_rs   = ADDR_W'($urandom_range(0, 7));
      #1;
      exp_ar = (m_q.size() < DEPTH) && (!bus.ld_valid  || !m_prio_ld);
      exp_lr = (m_q.size() < DEPTH) && (!bus.alu_valid ||  m_prio_ld);
      n_vec++;
      if ({bus.alu_ready, bus.ld_ready, full, empty} !==
          {exp_ar, exp_lr, m_q.size() == DEPTH, m_q.size() == 0}) begin
        n_bad++; $display("[TB] FAIL rnd_ready_c%0d: got %b expected %b", c,
                          {bus.alu_ready, bus.ld_ready, full, empty},
                          {exp_ar, exp_lr, m_q.size() == DEPTH, m_q.size() == 0});
      end
      n_vec++;
      if ({bus.q1_hit, bus.q1_data, bus.q2_hit, bus.q2_data} !==
          {model_query(bus.q1_rs), model_query(bus.q2_rs)}) begin
        n_bad++; $display("[TB] FAIL rnd_bypass_c%0d: got %0h/%0h expected %0h/%0h", c,
                          {bus.q1_hit, bus.q1_data}, {bus.q2_hit, bus.q2_data},
                          model_query(bus.q1_rs), model_query(bus.q2_rs));
      end
      tick();
      n_vec++;
      if ({bus.wb_we, bus.wb_rd, bus.wb_wd, count} !== {m_we, m_rd, m_wd, 3'(m_q.size())}) begin
        n_bad++; $display("[TB] FAIL rnd_wb_c%0d: got we=%b rd=%0d wd=%0h cnt=%0d expected we=%b rd=%0d wd=%0h cnt=%0d",
                          c, bus.wb_we, bus.wb_rd, bus.wb_wd, count, m_we, m_rd, m_wd, m_q.size());
      end
    end
    set_idle();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_latency();
    test_arbitration();
    test_full_hold();
    test_bypass();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
